// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: queues fetch-time predictions in order and checks them
// against execute outcomes, driving predictor/BTB updates, redirects and statistics.
module branch_resolve_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rec_valid,
  output logic                  rec_ready,
  input  logic [DATA_WIDTH-1:0] rec_pc,
  input  logic                  rec_hit,
  input  logic                  rec_pred,
  input  logic [DATA_WIDTH-1:0] rec_target,
  input  logic                  res_valid,
  input  logic                  res_is_cond,
  input  logic                  res_taken,
  input  logic [DATA_WIDTH-1:0] res_target,
  input  logic                  flush,
  output logic                  update_predictor,
  output logic                  update_btb,
  output logic                  actually_taken,
  output logic [DATA_WIDTH-1:0] resolved_pc,
  output logic [DATA_WIDTH-1:0] resolved_pc_target,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  res_underflow,
  output logic [CNT_WIDTH-1:0]  stat_branches,
  output logic [CNT_WIDTH-1:0]  stat_mispredicts
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(QUEUE_DEPTH);

  logic [DATA_WIDTH-1:0] pcMem_q  [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] tgtMem_q [QUEUE_DEPTH];
  logic                  hitMem_q [QUEUE_DEPTH];
  logic                  predMem_q[QUEUE_DEPTH];

  logic [PW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [PW:0]   count_q, count_d;

  logic                  updPred_q, updBtb_q, actTaken_q, mispred_q, underflow_q;
  logic [DATA_WIDTH-1:0] resPc_q, resTgt_q, redirect_q;
  logic [CNT_WIDTH-1:0]  statBr_q, statMis_q;

  logic                  resolve, taken, effTaken, mis, push;
  logic [DATA_WIDTH-1:0] headPc, headTgt, nextPc;
  logic                  headHit, headPred;

  assign rec_ready = (count_q != FULL_CNT);

  // Prediction check against the oldest entry; a jump with a BTB hit counts as predicted taken.
  always_comb begin
    headPc   = pcMem_q[rdPtr_q];
    headTgt  = tgtMem_q[rdPtr_q];
    headHit  = hitMem_q[rdPtr_q];
    headPred = predMem_q[rdPtr_q];
    resolve  = res_valid && (count_q != '0);
    taken    = res_taken | ~res_is_cond;
    effTaken = headHit & (headPred | ~res_is_cond);
    mis      = resolve & ((effTaken != taken) | (effTaken & taken & (headTgt != res_target)));
    push     = rec_valid & rec_ready & ~mis & ~flush;
    nextPc   = taken ? res_target : headPc + DATA_WIDTH'(4);
  end

  // Wrong-path entries vanish on a mispredict or flush by snapping the read pointer to the write pointer.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (mis || flush) begin
      rdPtr_d = wrPtr_q;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PW'(1);
      if (resolve) rdPtr_d = rdPtr_q + PW'(1);
      count_d = count_q + (PW+1)'(push) - (PW+1)'(resolve);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pcMem_q[i]   <= '0;
        tgtMem_q[i]  <= '0;
        hitMem_q[i]  <= 1'b0;
        predMem_q[i] <= 1'b0;
      end
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      updPred_q   <= 1'b0;
      updBtb_q    <= 1'b0;
      actTaken_q  <= 1'b0;
      mispred_q   <= 1'b0;
      underflow_q <= 1'b0;
      resPc_q     <= '0;
      resTgt_q    <= '0;
      redirect_q  <= '0;
      statBr_q    <= '0;
      statMis_q   <= '0;
    end else begin
      if (push) begin
        pcMem_q[wrPtr_q]   <= rec_pc;
        tgtMem_q[wrPtr_q]  <= rec_target;
        hitMem_q[wrPtr_q]  <= rec_hit;
        predMem_q[wrPtr_q] <= rec_pred;
      end
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
      updPred_q <= resolve & res_is_cond;
      updBtb_q  <= resolve & taken;
      mispred_q <= mis;
      if (resolve) begin
        actTaken_q <= taken;
        resPc_q    <= headPc;
        resTgt_q   <= res_target;
        redirect_q <= nextPc;
        if (statBr_q != '1) statBr_q <= statBr_q + CNT_WIDTH'(1);
      end
      if (mis && statMis_q != '1) statMis_q <= statMis_q + CNT_WIDTH'(1);
      if (res_valid && count_q == '0) underflow_q <= 1'b1;
    end
  end

  assign update_predictor   = updPred_q;
  assign update_btb         = updBtb_q;
  assign actually_taken     = actTaken_q;
  assign resolved_pc        = resPc_q;
  assign resolved_pc_target = resTgt_q;
  assign mispredict         = mispred_q;
  assign redirect_pc        = redirect_q;
  assign res_underflow      = underflow_q;
  assign stat_branches      = statBr_q;
  assign stat_mispredicts   = statMis_q;

endmodule
